// File: rtl/pf_ddr3_rx_lane_trainer_if.sv
// Lane-side bundle between the RX trainer and the IOD delay line / deserializer.
// The trainer uses master. The lane (IOD or its model) uses slave.
interface pf_ddr3_rx_lane_trainer_if;
    logic       START;
    logic [3:0] RX_DATA;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       RX_BIT_SLIP;
    logic       BUSY;
    logic       TRAINED;
    logic       TRAIN_FAIL;
    logic [7:0] TAP_CENTER;
    logic [7:0] WINDOW_WIDTH;

    modport master (
        input  START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, RX_BIT_SLIP,
        output BUSY, TRAINED, TRAIN_FAIL, TAP_CENTER, WINDOW_WIDTH
    );

    modport slave (
        output START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, RX_BIT_SLIP,
        input  BUSY, TRAINED, TRAIN_FAIL, TAP_CENTER, WINDOW_WIDTH
    );
endinterface

// File: rtl/pf_ddr3_rx_lane_trainer.sv
// DDR3 RX lane trainer: scans delay taps upward for the passing eye, centres the tap, then bit-slips to word alignment.
// The scan takes several thousand cycles. There is no backpressure. START is accepted only when not BUSY.
module pf_ddr3_rx_lane_trainer #(
    parameter logic [3:0] TRAIN_PATTERN = 4'b0011,
    parameter int         SETTLE_CYC    = 8,
    parameter int         MATCH_CYC     = 16,
    parameter int         MAX_TAP       = 127,
    parameter int         MIN_WINDOW    = 4
) (
    input logic                       FAB_CLK,
    input logic                       RESET_N,
    pf_ddr3_rx_lane_trainer_if.master lane
);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] MATCH_LAST  = 16'(MATCH_CYC - 1);
    localparam logic [7:0]  TAP_LIMIT   = 8'(MAX_TAP);
    localparam logic [7:0]  MIN_W       = 8'(MIN_WINDOW);
    localparam logic [3:0]  ROT1 = {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]};
    localparam logic [3:0]  ROT2 = {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]};
    localparam logic [3:0]  ROT3 = {TRAIN_PATTERN[0], TRAIN_PATTERN[3:1]};

    typedef enum logic [3:0] {
        IDLE, LOAD, SETTLE, CHECK, MOVE_UP, CENTER, SLIP, DONE, FAIL
    } state_t;

    state_t      state, nxt;
    logic [7:0]  tap, first, last, center_q, width_q;
    logic        have_first, slip_ph, dir_q, mv_ph;
    logic [1:0]  slip_cnt;
    logic [15:0] settle_cnt, chk_cnt;
    logic [3:0]  cap;

    logic        load_o, move_o, slip_o, busy_o, trained_o, fail_o;
    logic [3:0]  word;
    logic        same, chk_end, tap_pass, have_n, scan_end, width_ok;
    logic [7:0]  first_n, last_n, diff, width_n, center_n;

    // The first CHECK cycle is the capture cycle. It always counts as a match.
    assign word     = (chk_cnt == '0) ? lane.RX_DATA : cap;
    assign same     = slip_ph ? (lane.RX_DATA == TRAIN_PATTERN)
                              : ((chk_cnt == '0) || (lane.RX_DATA == cap));
    assign chk_end  = !same || (chk_cnt >= MATCH_LAST);
    assign tap_pass = same && (chk_cnt >= MATCH_LAST) &&
                      ((word == TRAIN_PATTERN) || (word == ROT1) ||
                       (word == ROT2) || (word == ROT3));

    assign have_n   = have_first | tap_pass;
    assign first_n  = have_first ? first : tap;
    assign last_n   = tap_pass ? tap : last;
    assign diff     = last_n - first_n;
    assign width_n  = !have_n ? 8'd0 : ((diff == 8'hFF) ? 8'hFF : diff + 8'd1);
    assign center_n = first_n + (diff >> 1);
    assign width_ok = have_n && (width_n >= MIN_W);
    assign scan_end = (!tap_pass && have_first) || (tap == TAP_LIMIT) ||
                      lane.DELAY_LINE_OUT_OF_RANGE;

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt       = state;
        load_o    = 1'b0;
        move_o    = 1'b0;
        slip_o    = 1'b0;
        busy_o    = 1'b1;
        trained_o = 1'b0;
        fail_o    = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (lane.START) nxt = LOAD;
            end
            DONE: begin
                busy_o    = 1'b0;
                trained_o = 1'b1;
                if (lane.START) nxt = LOAD;
            end
            FAIL: begin
                busy_o = 1'b0;
                fail_o = 1'b1;
                if (lane.START) nxt = LOAD;
            end
            LOAD: begin
                load_o = 1'b1;
                nxt    = SETTLE;
            end
            SETTLE: if (settle_cnt >= SETTLE_LAST) nxt = CHECK;
            CHECK: if (chk_end) begin
                if (slip_ph) begin
                    if (same)                 nxt = DONE;
                    else if (slip_cnt == 2'd3) nxt = FAIL;
                    else                      nxt = SLIP;
                end else if (scan_end) begin
                    nxt = width_ok ? CENTER : FAIL;
                end else begin
                    nxt = MOVE_UP;
                end
            end
            MOVE_UP: begin
                move_o = 1'b1;
                nxt    = SETTLE;
            end
            CENTER: begin
                move_o = mv_ph && (tap != center_q);
                if (tap == center_q) nxt = SETTLE;
            end
            SLIP: begin
                slip_o = 1'b1;
                nxt    = SETTLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            tap        <= '0;
            first      <= '0;
            last       <= '0;
            have_first <= 1'b0;
            center_q   <= '0;
            width_q    <= '0;
            slip_cnt   <= '0;
            slip_ph    <= 1'b0;
            dir_q      <= 1'b0;
            mv_ph      <= 1'b0;
            settle_cnt <= '0;
            chk_cnt    <= '0;
            cap        <= '0;
        end else begin
            if (state != SETTLE)        settle_cnt <= '0;
            else if (settle_cnt != '1)  settle_cnt <= settle_cnt + 16'd1;
            if (state != CHECK || chk_end) chk_cnt <= '0;
            else if (chk_cnt != '1)        chk_cnt <= chk_cnt + 16'd1;
            if (state == CHECK && chk_cnt == '0) cap <= lane.RX_DATA;

            case (state)
                LOAD: begin
                    tap        <= '0;
                    first      <= '0;
                    last       <= '0;
                    have_first <= 1'b0;
                    slip_cnt   <= '0;
                    slip_ph    <= 1'b0;
                    dir_q      <= 1'b1;
                end
                CHECK: if (chk_end && !slip_ph) begin
                    have_first <= have_n;
                    first      <= first_n;
                    last       <= last_n;
                    if (scan_end) begin
                        width_q  <= width_n;
                        center_q <= width_ok ? center_n : 8'd0;
                        mv_ph    <= 1'b0;
                        // Drop direction one cycle before the first down pulse.
                        if (width_ok) dir_q <= 1'b0;
                    end
                end
                MOVE_UP: if (tap < TAP_LIMIT) tap <= tap + 8'd1;
                CENTER: begin
                    if (tap != center_q) begin
                        if (mv_ph) tap <= tap - 8'd1;
                        mv_ph <= ~mv_ph;
                    end else begin
                        slip_ph <= 1'b1;
                    end
                end
                SLIP: if (slip_cnt != 2'd3) slip_cnt <= slip_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign lane.DELAY_LINE_LOAD      = load_o;
    assign lane.DELAY_LINE_MOVE      = move_o;
    assign lane.DELAY_LINE_DIRECTION = dir_q;
    assign lane.RX_BIT_SLIP          = slip_o;
    assign lane.BUSY                 = busy_o;
    assign lane.TRAINED              = trained_o;
    assign lane.TRAIN_FAIL           = fail_o;
    assign lane.TAP_CENTER           = center_q;
    assign lane.WINDOW_WIDTH         = width_q;
endmodule

// File: tb/tb_pf_ddr3_rx_lane_trainer.sv
// Bench for the RX lane trainer: a behavioural IOD lane model with a tap-window eye and a slip-alignment word.
module tb_pf_ddr3_rx_lane_trainer;
    localparam logic [3:0] PAT    = 4'b0011;
    localparam int         SETTLE = 8;
    localparam int         MATCH  = 16;
    localparam int         MAXT   = 127;
    localparam int         MINW   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pf_ddr3_rx_lane_trainer_if lane_if();

    pf_ddr3_rx_lane_trainer #(
        .TRAIN_PATTERN(PAT), .SETTLE_CYC(SETTLE), .MATCH_CYC(MATCH),
        .MAX_TAP(MAXT), .MIN_WINDOW(MINW)
    ) dut (
        .FAB_CLK(clk),
        .RESET_N(rst_n),
        .lane   (lane_if)
    );

    int checks = 0;
    int errors = 0;
    int test_id = 0;

    int cfg_lo = 1000, cfg_hi = -1, cfg_need = 0, cfg_honor = 1, cfg_oor = 1000;

    int m_tap = 0, m_got = 0;
    int loads = 0, ups = 0, downs = 0, slips = 0, cyc = 0, last_slip = -1000;
    int proto_bad = 0;
    string proto_what = "none";
    logic prev_dir = 1'b0, prev_move = 1'b0, prev_load = 1'b0;
    logic [3:0] last_rx = 4'd0;

    function automatic logic [3:0] rot(input logic [3:0] p, input int k);
        logic [7:0] d;
        d = {p, p} << k;
        return d[7:4];
    endfunction

    // Lane model: taps in [cfg_lo,cfg_hi] give a stable word. That word is aligned once cfg_need slips have landed.
    always @(negedge clk) begin : lane_model
        logic [3:0] w;
        cyc++;
        if (lane_if.DELAY_LINE_LOAD === 1'b1) begin
            loads++;
            m_tap = 0;
            m_got = 0;
            if (prev_load) begin proto_bad++; proto_what = "load_wide"; end
        end
        if (lane_if.DELAY_LINE_MOVE === 1'b1) begin
            if (lane_if.DELAY_LINE_DIRECTION !== prev_dir) begin proto_bad++; proto_what = "dir_not_settled"; end
            if (prev_move) begin proto_bad++; proto_what = "move_back_to_back"; end
            if (lane_if.DELAY_LINE_DIRECTION) begin ups++; m_tap++; end
            else begin downs++; m_tap--; end
        end
        if (lane_if.RX_BIT_SLIP === 1'b1) begin
            if (cyc - last_slip <= SETTLE) begin proto_bad++; proto_what = "slip_no_settle"; end
            slips++;
            last_slip = cyc;
            if (cfg_honor != 0) m_got++;
        end
        if (lane_if.TRAINED === 1'b1 && lane_if.TRAIN_FAIL === 1'b1) begin
            proto_bad++; proto_what = "trained_and_fail";
        end
        prev_dir  = lane_if.DELAY_LINE_DIRECTION;
        prev_move = lane_if.DELAY_LINE_MOVE;
        prev_load = lane_if.DELAY_LINE_LOAD;

        lane_if.DELAY_LINE_OUT_OF_RANGE = (m_tap >= cfg_oor);
        if (m_tap >= cfg_lo && m_tap <= cfg_hi) begin
            w = rot(PAT, ((cfg_need - m_got) % 4 + 4) % 4);
        end else begin
            w = 4'($urandom);
            if (w == last_rx) w = ~w;
        end
        lane_if.RX_DATA = w;
        last_rx = w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL test %0d %s observed %0d expected %0d", test_id, tag, obs, exp);
        end
    endtask

    // Closed-form result from the eye window, range limit and slip needs.
    function automatic void expect_of(input int lo, hi, need, honor, oor,
                                      output int e_ups, e_downs, e_width, e_center,
                                      output int e_slips, e_trained);
        int stop, last;
        stop = (MAXT < oor) ? MAXT : oor;
        if (hi >= lo && hi + 1 < stop) stop = hi + 1;
        last = (hi < stop) ? hi : stop;
        e_ups = stop;
        e_width = (lo <= stop && lo <= hi) ? last - lo + 1 : 0;
        e_center = 0; e_downs = 0; e_slips = 0; e_trained = 0;
        if (e_width >= MINW) begin
            e_center = lo + (last - lo) / 2;
            e_downs  = stop - e_center;
            if (need == 0)       e_trained = 1;
            else if (honor != 0) begin e_slips = need; e_trained = 1; end
            else                 e_slips = 3;
        end
    endfunction

    task automatic kick();
        @(negedge clk); #1 lane_if.START = 1'b1;
        @(negedge clk); #1 lane_if.START = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 20000 && lane_if.BUSY === 1'b1; c++) begin
            @(negedge clk); #1;
        end
        chk("done_within_budget", 32'(c < 20000), 1);
    endtask

    task automatic check_zero_outputs();
        chk("rst_busy",   32'(lane_if.BUSY), 0);
        chk("rst_trained", 32'(lane_if.TRAINED), 0);
        chk("rst_train_fail", 32'(lane_if.TRAIN_FAIL), 0);
        chk("rst_load",   32'(lane_if.DELAY_LINE_LOAD), 0);
        chk("rst_move",   32'(lane_if.DELAY_LINE_MOVE), 0);
        chk("rst_dir",    32'(lane_if.DELAY_LINE_DIRECTION), 0);
        chk("rst_slip",   32'(lane_if.RX_BIT_SLIP), 0);
        chk("rst_center", 32'(lane_if.TAP_CENTER), 0);
        chk("rst_width",  32'(lane_if.WINDOW_WIDTH), 0);
    endtask

    task automatic run_train(input int lo, hi, need, honor, oor);
        int e_ups, e_downs, e_width, e_center, e_slips, e_trained;
        int b_loads, b_ups, b_downs, b_slips, b_proto;
        test_id++;
        cfg_lo = lo; cfg_hi = hi; cfg_need = need; cfg_honor = honor; cfg_oor = oor;
        expect_of(lo, hi, need, honor, oor, e_ups, e_downs, e_width, e_center, e_slips, e_trained);
        b_loads = loads; b_ups = ups; b_downs = downs; b_slips = slips; b_proto = proto_bad;
        kick();
        chk("busy_after_start", 32'(lane_if.BUSY), 1);
        chk("trained_cleared", 32'(lane_if.TRAINED), 0);
        wait_idle();
        chk("trained",    32'(lane_if.TRAINED), 32'(e_trained));
        chk("train_fail", 32'(lane_if.TRAIN_FAIL), 32'(1 - e_trained));
        chk("window_width", 32'(lane_if.WINDOW_WIDTH), 32'(e_width));
        if (e_width >= MINW) chk("tap_center", 32'(lane_if.TAP_CENTER), 32'(e_center));
        chk("up_moves",   32'(ups - b_ups), 32'(e_ups));
        chk("down_moves", 32'(downs - b_downs), 32'(e_downs));
        chk("bit_slips",  32'(slips - b_slips), 32'(e_slips));
        chk("load_pulses", 32'(loads - b_loads), 1);
        chk({"protocol_", proto_what}, 32'(proto_bad - b_proto), 0);
    endtask

    initial begin
        int c, b_loads, lo, hi;
        rst_n = 1'b0;
        lane_if.START = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_zero_outputs();
        rst_n = 1'b1;

        run_train(20, 39, 0, 1, 1000);   // aligned, wide eye
        run_train(10, 13, 3, 1, 1000);   // minimum window, three slips
        run_train(10, 12, 0, 1, 1000);   // window too narrow
        run_train(50, 127, 0, 1, 60);    // range flag stops the scan
        run_train(20, 39, 2, 0, 1000);   // lane ignores slips

        // Reset in the middle of a scan, with a START that must be ignored while busy.
        test_id++;
        cfg_lo = 20; cfg_hi = 39; cfg_need = 0; cfg_honor = 1; cfg_oor = 1000;
        b_loads = loads;
        kick();
        for (c = 0; c < 5000 && m_tap < 10; c++) begin @(negedge clk); #1; end
        chk("reach_tap10", 32'(m_tap >= 10), 1);
        kick();
        chk("start_ignored_busy", 32'(lane_if.BUSY), 1);
        chk("start_ignored_load", 32'(loads - b_loads), 1);
        for (c = 0; c < 5000 && m_tap < 30; c++) begin @(negedge clk); #1; end
        chk("reach_tap30", 32'(m_tap), 30);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs();
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("no_load_from_reset", 32'(loads - b_loads), 1);
        chk("idle_after_reset", 32'(lane_if.BUSY), 0);
        run_train(20, 39, 0, 1, 1000);

        for (int i = 0; i < 4; i++) begin
            lo = ($urandom_range(0, 4) == 0) ? 200 : int'($urandom_range(0, 110));
            hi = lo + int'($urandom_range(0, 25));
            run_train(lo, hi, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? lo + int'($urandom_range(0, 30)) : 1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pf_ddr3_rx_lane_trainer.md
PF_DDR3_RX_LANE_TRAINER -- requirements
Module: pf_ddr3_rx_lane_trainer

Interface
REQ-001 The block SHALL have parameter TRAIN_PATTERN, default 4'b0011: expected aligned 4-bit RX word per FAB_CLK.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 8: idle cycles after any delay-line or bit-slip action before sampling.
REQ-003 The block SHALL have parameter MATCH_CYC, default 16: consecutive stable cycles required for a tap to pass.
REQ-004 The block SHALL have parameter MAX_TAP, default 127: highest tap scanned.
REQ-005 The block SHALL have parameter MIN_WINDOW, default 4: minimum passing-window width in taps.
REQ-006 The block SHALL have port FAB_CLK, input, 1 bit: the single clock; all logic rising-edge.
REQ-007 The block SHALL have port RESET_N, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port START, input, 1 bit: one-cycle training request.
REQ-009 The block SHALL have port RX_DATA, input, 4 bits: deserialized lane word from IOD RX path.
REQ-010 The block SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1 bit: IOD delay-line range flag.
REQ-011 The block SHALL have ports DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, RX_BIT_SLIP, each output, 1 bit: IOD controls (DIRECTION 1 = increment).
REQ-012 The block SHALL have ports BUSY, TRAINED, TRAIN_FAIL, each output, 1 bit: status.
REQ-013 The block SHALL have ports TAP_CENTER and WINDOW_WIDTH, each output, 8 bits: result of the last completed scan.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SETTLE, CHECK, MOVE_UP, CENTER, SLIP, DONE, FAIL.
REQ-015 In IDLE, DONE or FAIL, START=1 SHALL enter LOAD, clear TRAINED/TRAIN_FAIL and set BUSY; START while BUSY SHALL be ignored.
REQ-016 LOAD SHALL pulse DELAY_LINE_LOAD for exactly 1 cycle, set internal tap counter to 0 and slip counter to 0, then enter SETTLE.
REQ-017 SETTLE SHALL count SETTLE_CYC cycles, then enter CHECK.
REQ-018 CHECK SHALL capture RX_DATA in its first cycle; a tap passes when RX_DATA equals the captured value for MATCH_CYC consecutive cycles (capture cycle included) and the captured value is one of the 4 rotations of TRAIN_PATTERN; any mismatch SHALL fail the tap immediately.
REQ-019 During scan, the first passing tap SHALL be recorded as FIRST and each later contiguous passing tap as LAST.
REQ-020 Scan SHALL end on the first failing tap after a pass, on a check completed at tap MAX_TAP, or on DELAY_LINE_OUT_OF_RANGE=1 sampled at the end of a check; otherwise MOVE_UP SHALL issue one DELAY_LINE_MOVE pulse with DIRECTION=1, increment the tap counter, and re-enter SETTLE.
REQ-021 DIRECTION SHALL be stable at least 1 cycle before and through every MOVE pulse; MOVE pulses SHALL be 1 cycle wide, separated by at least 1 low cycle.
REQ-022 At scan end, WINDOW_WIDTH SHALL be LAST-FIRST+1, or 0 if no tap passed; width < MIN_WINDOW SHALL enter FAIL.
REQ-023 Otherwise TAP_CENTER SHALL be FIRST+((LAST-FIRST)>>1) (floor), and CENTER SHALL issue exactly (tap counter - TAP_CENTER) MOVE pulses with DIRECTION=0, then SETTLE.
REQ-024 After centring, SLIP phase: if RX_DATA equals TRAIN_PATTERN for MATCH_CYC cycles, enter DONE; else pulse RX_BIT_SLIP for 1 cycle, increment slip counter, wait SETTLE_CYC, recheck; a failing check after the 3rd slip SHALL enter FAIL.
REQ-025 DONE SHALL hold TRAINED=1, BUSY=0; FAIL SHALL hold TRAIN_FAIL=1, BUSY=0; TRAINED and TRAIN_FAIL SHALL never be 1 together.
REQ-026 All internal counters SHALL saturate, never wrap; the tap counter SHALL never exceed MAX_TAP.

Reset
REQ-027 RESET_N=0 at a clock edge SHALL force IDLE, with all outputs 0 (TAP_CENTER=0, WINDOW_WIDTH=0) from that edge, regardless of state.
REQ-028 Reset mid-training SHALL NOT itself pulse DELAY_LINE_LOAD; the delay line is reloaded only by the next START.

Verification
REQ-029 Lane model passes taps 20..39, word already aligned; START -> 40 up-MOVE pulses, 11 down-MOVE pulses, TAP_CENTER=29, WINDOW_WIDTH=20, 0 RX_BIT_SLIP pulses, TRAINED=1.
REQ-030 Passing taps 10..13, model needs 3 slips; START -> TAP_CENTER=11, WINDOW_WIDTH=4, exactly 3 RX_BIT_SLIP pulses each followed by >= SETTLE_CYC idle cycles, TRAINED=1.
REQ-031 Passing taps 10..12 -> WINDOW_WIDTH=3, TRAIN_FAIL=1, TRAINED=0, no down-MOVE or RX_BIT_SLIP pulses.
REQ-032 Passing taps 50..127 with OUT_OF_RANGE asserted at tap 60 -> scan stops at 60, WINDOW_WIDTH=11, TAP_CENTER=55, 5 down-MOVE pulses.
REQ-033 Model ignores RX_BIT_SLIP, window 20..39 -> 3 slip pulses then TRAIN_FAIL=1.
REQ-034 RESET_N=0 for 1 cycle at tap 30 -> all outputs 0 from that edge; START pulse mid-scan ignored; new START -> 1-cycle LOAD pulse and scan restarts at tap 0.
